uart_axifull_burst_slave: RTL

- AXI4-full slave (responder) fronting the UART IP's burst buffer: accepts INCR/FIXED/WRAP write and read bursts from the interconnect master and stores 32-bit words in an internal word-addressed RAM.
- Independent write and read channel FSMs, one outstanding transaction per direction.
- Sits between the AXI interconnect and the UART TX/RX data path; the UART core reads and writes the RAM through a separate port outside this block's scope.

---
 rtl/uart_axifull_pkg.sv | 46 ++++
 rtl/uart_axifull_bram.sv | 49 ++++
 rtl/uart_axifull_burst_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axifull_pkg.sv
// Shared definitions for the UART burst-buffer AXI4-full slave.
// Burst/response encodings, channel state enums and the burst address
// stepping helpers used by both the write and read channels.
package uart_axifull_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // WRAP is only meaningful for 2, 4, 8 or 16 beats; the reserved type never is.
  function automatic logic burst_legal(input logic [1:0] burst, input logic [7:0] len);
    case (burst)
      BURST_FIXED, BURST_INCR: burst_legal = 1'b1;
      BURST_WRAP: burst_legal = (len == 8'd1) || (len == 8'd3) ||
                                (len == 8'd7) || (len == 8'd15);
      default: burst_legal = 1'b0;
    endcase
  endfunction

  // Illegal bursts are stepped as INCR (the response carries the error).
  function automatic logic [1:0] burst_effective(input logic [1:0] burst, input logic [7:0] len);
    burst_effective = burst_legal(burst, len) ? burst : BURST_INCR;
  endfunction

  // Address of the beat following addr. Callers truncate to their own width,
  // which provides the modulo-2^ADDR_WIDTH wrap for INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic [31:0] span_mask;
    logic [31:0] incr;
    span_mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
    incr      = addr + 32'd4;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~span_mask) | (incr & span_mask);
      default:     next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/uart_axifull_bram.sv
// Dual-port word RAM with byte enables for the UART burst buffer.
// AXI side: one byte-enabled write port plus one read port (independent
// addresses so the AXI write and read channels can run concurrently).
// UART side: combined read/write port. All reads are registered and
// read-first; an output register only updates when its enable is high.
// A same-byte write collision between AXI and UART resolves to the UART.
//   clk                      clock
//   wr_en/wr_be/wr_addr/wr_data   AXI write port
//   rd_en/rd_addr/rd_data         AXI read port
//   u_en/u_we/u_addr/u_wdata/u_rdata  UART port
module uart_axifull_bram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  u_en,
  input  logic [DATA_W/8-1:0]   u_we,
  input  logic [ADDR_W-1:0]     u_addr,
  input  logic [DATA_W-1:0]     u_wdata,
  output logic [DATA_W-1:0]     u_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // One byte-wide array per lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    logic [7:0] u_q;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[gi]) mem[wr_addr] <= wr_data[gi*8 +: 8];
      if (u_en && u_we[gi])   mem[u_addr]  <= u_wdata[gi*8 +: 8];
      if (rd_en)              rd_q         <= mem[rd_addr];
      if (u_en)               u_q          <= mem[u_addr];
    end

    assign rd_data[gi*8 +: 8] = rd_q;
    assign u_rdata[gi*8 +: 8] = u_q;
  end

endmodule

// File: rtl/uart_axifull_burst_slave.sv
// AXI4-full slave fronting the UART burst buffer. Independent write
// (IDLE->WDATA->WRESP) and read (IDLE->RDATA) channels, one outstanding
// burst each, storing 32-bit words in an internal word-addressed RAM.
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*       write address, data and response channels
//   S_AXI_AR*/R*          read address and data channels
//   uart_*                RAM port exported to the UART core
// Side-band inputs (LOCK/CACHE/PROT/QOS/REGION/USER) are ignored; USER outputs are 0.
module uart_axifull_burst_slave
  import uart_axifull_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_USER_WIDTH = 1
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic [3:0]                        S_AXI_AWQOS,
  input  logic [3:0]                        S_AXI_AWREGION,
  input  logic [C_S_AXI_USER_WIDTH-1:0]     S_AXI_AWUSER,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic [C_S_AXI_USER_WIDTH-1:0]     S_AXI_WUSER,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                        S_AXI_BRESP,
  output logic [C_S_AXI_USER_WIDTH-1:0]     S_AXI_BUSER,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic [3:0]                        S_AXI_ARQOS,
  input  logic [3:0]                        S_AXI_ARREGION,
  input  logic [C_S_AXI_USER_WIDTH-1:0]     S_AXI_ARUSER,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic [C_S_AXI_USER_WIDTH-1:0]     S_AXI_RUSER,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              uart_en,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   uart_we,
  input  logic [C_S_AXI_ADDR_WIDTH-3:0]     uart_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     uart_wdata,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     uart_rdata
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  // Keeps AWREADY/ARREADY low while reset is held and for the first edge after release.
  logic out_en_reg;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) out_en_reg <= 1'b0;
    else          out_en_reg <= 1'b1;
  end

  // ---------------- write channel ----------------
  wr_state_t                   wr_state_reg, wr_state_next;
  logic [C_S_AXI_ID_WIDTH-1:0] aw_id_reg;
  logic [AW-1:0]               aw_addr_reg;
  logic [7:0]                  aw_len_reg, wr_cnt_reg;
  logic [1:0]                  aw_burst_reg;
  logic                        wr_err_reg;
  logic                        aw_hs, w_hs, b_hs, w_last_beat;
  logic [31:0]                 wr_next_full;

  assign aw_hs        = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs         = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs         = S_AXI_BVALID & S_AXI_BREADY;
  assign w_last_beat  = (wr_cnt_reg == aw_len_reg);
  assign wr_next_full = next_addr(32'(aw_addr_reg), aw_burst_reg, aw_len_reg);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_state_reg <= W_IDLE;
    else          wr_state_reg <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE:  if (aw_hs)                wr_state_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat)  wr_state_next = W_RESP;
      W_RESP:  if (b_hs)                 wr_state_next = W_IDLE;
      default:                           wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = out_en_reg && (wr_state_reg == W_IDLE);
    S_AXI_WREADY  = (wr_state_reg == W_DATA);
    S_AXI_BVALID  = (wr_state_reg == W_RESP);
    S_AXI_BRESP   = (S_AXI_BVALID && wr_err_reg) ? RESP_SLVERR : RESP_OKAY;
    S_AXI_BID     = aw_id_reg;
    S_AXI_BUSER   = '0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_id_reg    <= '0;
      aw_addr_reg  <= '0;
      aw_len_reg   <= '0;
      aw_burst_reg <= BURST_INCR;
      wr_cnt_reg   <= '0;
      wr_err_reg   <= 1'b0;
    end else if (aw_hs) begin
      aw_id_reg    <= S_AXI_AWID;
      aw_addr_reg  <= {S_AXI_AWADDR[AW-1:2], 2'b00};
      aw_len_reg   <= S_AXI_AWLEN;
      aw_burst_reg <= burst_effective(S_AXI_AWBURST, S_AXI_AWLEN);
      wr_cnt_reg   <= '0;
      wr_err_reg   <= (S_AXI_AWSIZE != 3'd2) || !burst_legal(S_AXI_AWBURST, S_AXI_AWLEN);
    end else if (w_hs) begin
      aw_addr_reg <= wr_next_full[AW-1:0];
      wr_cnt_reg  <= wr_cnt_reg + 8'd1;
      if (S_AXI_WLAST != w_last_beat) wr_err_reg <= 1'b1;
    end
  end

  // ---------------- read channel ----------------
  rd_state_t                   rd_state_reg, rd_state_next;
  logic [C_S_AXI_ID_WIDTH-1:0] ar_id_reg;
  logic [AW-1:0]               ar_addr_reg;
  logic [7:0]                  ar_len_reg, rd_cnt_reg;
  logic [1:0]                  ar_burst_reg;
  logic                        rd_err_reg;
  logic                        ar_hs, r_hs, r_last_beat;
  logic [31:0]                 rd_next_full;
  logic                        ram_rd_en;
  logic [AW-3:0]               ram_rd_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rd_data;

  assign ar_hs        = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs         = S_AXI_RVALID & S_AXI_RREADY;
  assign r_last_beat  = (rd_cnt_reg == ar_len_reg);
  assign rd_next_full = next_addr(32'(ar_addr_reg), ar_burst_reg, ar_len_reg);

  // The RAM output register is the R data holding register: it only
  // reloads on the AR handshake or when a non-final beat is accepted,
  // so RDATA stays put while stalled and the next beat is ready one cycle later.
  assign ram_rd_en   = ar_hs | (r_hs & ~r_last_beat);
  assign ram_rd_addr = ar_hs ? S_AXI_ARADDR[AW-1:2] : rd_next_full[AW-1:2];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state_reg <= R_IDLE;
    else          rd_state_reg <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      R_IDLE:  if (ar_hs)               rd_state_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) rd_state_next = R_IDLE;
      default:                          rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = out_en_reg && (rd_state_reg == R_IDLE);
    S_AXI_RVALID  = (rd_state_reg == R_DATA);
    S_AXI_RLAST   = S_AXI_RVALID && r_last_beat;
    S_AXI_RRESP   = (S_AXI_RVALID && rd_err_reg) ? RESP_SLVERR : RESP_OKAY;
    S_AXI_RDATA   = S_AXI_RVALID ? ram_rd_data : '0;
    S_AXI_RID     = ar_id_reg;
    S_AXI_RUSER   = '0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_id_reg    <= '0;
      ar_addr_reg  <= '0;
      ar_len_reg   <= '0;
      ar_burst_reg <= BURST_INCR;
      rd_cnt_reg   <= '0;
      rd_err_reg   <= 1'b0;
    end else if (ar_hs) begin
      ar_id_reg    <= S_AXI_ARID;
      ar_addr_reg  <= {S_AXI_ARADDR[AW-1:2], 2'b00};
      ar_len_reg   <= S_AXI_ARLEN;
      ar_burst_reg <= burst_effective(S_AXI_ARBURST, S_AXI_ARLEN);
      rd_cnt_reg   <= '0;
      rd_err_reg   <= (S_AXI_ARSIZE != 3'd2) || !burst_legal(S_AXI_ARBURST, S_AXI_ARLEN);
    end else if (r_hs && !r_last_beat) begin
      ar_addr_reg <= rd_next_full[AW-1:0];
      rd_cnt_reg  <= rd_cnt_reg + 8'd1;
    end
  end

  uart_axifull_bram #(
    .ADDR_W (AW-2),
    .DATA_W (C_S_AXI_DATA_WIDTH)
  ) u_bram (
    .clk     (ACLK),
    .wr_en   (w_hs),
    .wr_be   (S_AXI_WSTRB),
    .wr_addr (aw_addr_reg[AW-1:2]),
    .wr_data (S_AXI_WDATA),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data),
    .u_en    (uart_en),
    .u_we    (uart_we),
    .u_addr  (uart_addr),
    .u_wdata (uart_wdata),
    .u_rdata (uart_rdata)
  );

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                           S_AXI_AWREGION, S_AXI_AWUSER, S_AXI_AWADDR[1:0], S_AXI_WUSER,
                           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                           S_AXI_ARREGION, S_AXI_ARUSER, S_AXI_ARADDR[1:0],
                           wr_next_full[31:AW], rd_next_full[31:AW], rd_next_full[1:0]};

endmodule
